// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and decode/execute.
//
// Handshake rule for the decode side: a word is transferred on a rising edge
// where InstrValid=1 and InstrReady=1 and Branch=0. While InstrValid=1 and no
// transfer has happened, Instr and InstrPC stay stable. A Branch pulse wins
// over a simultaneous InstrReady, and that cycle does not count as a transfer.
interface fetch_unit_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              MemRead;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] MemData;
  logic [DATA_W-1:0] Instr;
  logic              InstrValid;
  logic              InstrReady;
  logic [ADDR_W-1:0] InstrPC;
  logic              Branch;
  logic [ADDR_W-1:0] BranchTarget;

  // Fetch-unit side
  modport master (
    output MemRead, ADDR, Instr, InstrValid, InstrPC,
    input  MemData, InstrReady, Branch, BranchTarget
  );

  // Memory / decode / execute side
  modport slave (
    input  MemRead, ADDR, Instr, InstrValid, InstrPC,
    output MemData, InstrReady, Branch, BranchTarget
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues single-word reads, captures the
// returned word and presents it to decode. A branch redirect squashes any
// in-flight or held fetch.
module fetch_unit #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int MEM_LAT  = 1,
  parameter int RESET_PC = 0
) (
  input  logic       CLK,
  input  logic       reset,
  fetch_unit_if.master bus,
  output logic [1:0] o_dbg_state
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_squash;
  logic [CNT_W-1:0]  r_cnt;

  // Sequencer: PC, instruction register, squash flag and latency counter.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= ADDR_W'(RESET_PC);
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_squash   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Branch) r_pc <= bus.BranchTarget;
          r_state <= S_REQ;
        end
        S_REQ: begin
          r_cnt   <= CNT_INIT;
          r_state <= S_WAIT;
          if (bus.Branch) begin
            r_pc     <= bus.BranchTarget;
            r_squash <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            // Final wait cycle: MemData is valid now. A branch arriving on
            // this very cycle squashes the word just like an earlier one.
            if (r_squash || bus.Branch) begin
              if (bus.Branch) r_pc <= bus.BranchTarget;
              r_squash <= 1'b0;
              r_state  <= S_REQ;
            end else begin
              r_instr    <= bus.MemData;
              r_instr_pc <= r_pc;
              r_pc       <= r_pc + 1'b1;
              r_state    <= S_HOLD;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (bus.Branch) begin
              r_pc     <= bus.BranchTarget;
              r_squash <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (bus.Branch) begin
            r_pc    <= bus.BranchTarget;
            r_state <= S_REQ;
          end else if (bus.InstrReady) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded directly from registered state.
  always_comb begin
    bus.MemRead    = (r_state == S_REQ);
    bus.ADDR       = r_pc;
    bus.Instr      = r_instr;
    bus.InstrPC    = r_instr_pc;
    bus.InstrValid = (r_state == S_HOLD);
    o_dbg_state    = r_state;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a synchronous-read memory model and
// a scoreboard of words decode is expected to accept.
module tb_fetch_unit;

  logic       CLK = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  logic [15:0] mem [16];
  logic [19:0] exp_q [$];
  int n_compared   = 0;
  int n_mismatched = 0;

  fetch_unit_if #(.ADDR_W(4), .DATA_W(16)) bus ();

  fetch_unit #(.ADDR_W(4), .DATA_W(16), .MEM_LAT(1), .RESET_PC(0)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock
  always #5 CLK = ~CLK;

  // Synchronous-read memory: data appears the cycle after MemRead; junk otherwise.
  always @(posedge CLK) begin
    if (bus.MemRead) bus.MemData <= mem[bus.ADDR];
    else             bus.MemData <= 16'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] pc);
    exp_q.push_back({pc, mem[pc]});
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!bus.InstrValid && n < max_cycles) begin
      step();
      n++;
    end
    check("valid_within_bound", 32'(bus.InstrValid), 32'd1);
  endtask

  // Scoreboard: pop on every completed decode handshake.
  always @(negedge CLK) begin
    if (!reset && bus.InstrValid && bus.InstrReady && !bus.Branch) begin
      if (exp_q.size() == 0) begin
        check("spurious_accept", 32'd1, 32'd0);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("accept_pc",   32'(bus.InstrPC), 32'(e[19:16]));
        check("accept_data", 32'(bus.Instr),   32'(e[15:0]));
      end
    end
  end

  initial begin
    logic [3:0] exp_pc;
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h13F7;
    mem[1] = 16'hB00B;
    mem[2] = 16'hC0DE;
    mem[3] = 16'hD00D;

    reset = 1'b1;
    bus.InstrReady   = 1'b0;
    bus.Branch       = 1'b0;
    bus.BranchTarget = 4'd0;
    repeat (3) step();
    check("rst_memread", 32'(bus.MemRead),    32'd0);
    check("rst_valid",   32'(bus.InstrValid), 32'd0);
    check("rst_addr",    32'(bus.ADDR),       32'd0);
    check("rst_instr",   32'(bus.Instr),      32'd0);
    check("rst_state",   32'(dbg_state),      32'd0);

    // First fetch and a back-to-back stream of four words
    for (int i = 0; i < 4; i++) push_exp(4'(i));
    bus.InstrReady = 1'b1;
    reset = 1'b0;
    step();
    check("t1_memread", 32'(bus.MemRead), 32'd1);
    check("t1_addr",    32'(bus.ADDR),    32'd0);
    step();
    check("t1_wait_memread", 32'(bus.MemRead),    32'd0);
    check("t1_wait_valid",   32'(bus.InstrValid), 32'd0);
    step();
    check("t1_valid",   32'(bus.InstrValid), 32'd1);
    check("t1_instr",   32'(bus.Instr),      32'h13F7);
    check("t1_instrpc", 32'(bus.InstrPC),    32'd0);
    step();
    for (int i = 1; i < 4; i++) begin
      check("t2_memread", 32'(bus.MemRead), 32'd1);
      check("t2_addr",    32'(bus.ADDR),    32'(i));
      step();
      step();
      check("t2_valid", 32'(bus.InstrValid), 32'd1);
      check("t2_instr", 32'(bus.Instr),      32'(mem[i]));
      step();
    end
    check("t2_next_addr", 32'(bus.ADDR), 32'd4);

    // Decode stalls for five cycles in HOLD
    bus.InstrReady = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("t3_valid",   32'(bus.InstrValid), 32'd1);
      check("t3_instr",   32'(bus.Instr),      32'(mem[4]));
      check("t3_memread", 32'(bus.MemRead),    32'd0);
      check("t3_addr",    32'(bus.ADDR),       32'd5);
      step();
    end
    push_exp(4'd4);
    bus.InstrReady = 1'b1;
    step();
    check("t3_release_memread", 32'(bus.MemRead), 32'd1);
    check("t3_release_addr",    32'(bus.ADDR),    32'd5);

    // Branch + ready in HOLD: branch wins, then fetch from 15 wraps to 0
    bus.InstrReady = 1'b0;
    step();
    step();
    check("t4_hold_pc", 32'(bus.InstrPC), 32'd5);
    bus.Branch = 1'b1;
    bus.BranchTarget = 4'd15;
    bus.InstrReady = 1'b1;
    step();
    bus.Branch = 1'b0;
    check("t4_br_memread", 32'(bus.MemRead),    32'd1);
    check("t4_br_addr",    32'(bus.ADDR),       32'd15);
    check("t4_br_valid",   32'(bus.InstrValid), 32'd0);
    push_exp(4'd15);
    step();
    step();
    check("t4_instrpc", 32'(bus.InstrPC), 32'd15);
    check("t4_instr",   32'(bus.Instr),   32'(mem[15]));
    step();
    check("t4_wrap_addr", 32'(bus.ADDR), 32'd0);

    // Branch during WAIT squashes the word in flight
    step();
    bus.Branch = 1'b1;
    bus.BranchTarget = 4'd9;
    step();
    bus.Branch = 1'b0;
    check("t5_addr",  32'(bus.ADDR),       32'd9);
    check("t5_req",   32'(bus.MemRead),    32'd1);
    check("t5_valid", 32'(bus.InstrValid), 32'd0);
    push_exp(4'd9);
    step();
    step();
    check("t5_instr", 32'(bus.Instr), 32'(mem[9]));
    step();
    check("t5_next_addr", 32'(bus.ADDR), 32'd10);
    // Two pulses during one squash: the last target wins
    bus.Branch = 1'b1;
    bus.BranchTarget = 4'd7;
    step();
    check("t5_sq_memread", 32'(bus.MemRead), 32'd0);
    bus.BranchTarget = 4'd3;
    step();
    bus.Branch = 1'b0;
    check("t5_last_addr",  32'(bus.ADDR),       32'd3);
    check("t5_last_valid", 32'(bus.InstrValid), 32'd0);
    check("t5_last_req",   32'(bus.MemRead),    32'd1);
    push_exp(4'd3);
    step();
    step();
    check("t5_last_instr", 32'(bus.Instr), 32'(mem[3]));
    step();

    // Reset during WAIT
    step();
    reset = 1'b1;
    step();
    check("t6_valid",   32'(bus.InstrValid), 32'd0);
    check("t6_memread", 32'(bus.MemRead),    32'd0);
    check("t6_addr",    32'(bus.ADDR),       32'd0);
    check("t6_state",   32'(dbg_state),      32'd0);
    reset = 1'b0;
    step();
    check("t6_req_addr", 32'(bus.ADDR), 32'd0);
    push_exp(4'd0);
    step();
    step();
    check("t6_instr", 32'(bus.Instr), 32'h13F7);
    step();

    // Random decode stalls over a run of sequential fetches
    bus.InstrReady = 1'b0;
    exp_pc = 4'd1;
    for (int k = 0; k < 10; k++) begin
      wait_valid(8);
      check("rnd_pc",    32'(bus.InstrPC), 32'(exp_pc));
      check("rnd_instr", 32'(bus.Instr),   32'(mem[exp_pc]));
      repeat ($urandom_range(0, 3)) step();
      push_exp(exp_pc);
      bus.InstrReady = 1'b1;
      step();
      bus.InstrReady = 1'b0;
      exp_pc = exp_pc + 4'd1;
    end

    repeat (3) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global time limit
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
